// File: rtl/single_ram_arbiter_pkg.sv
// Shared definitions for the single-RAM round-robin access controller:
// FSM state encodings and the requester-index width helper.
package single_ram_arbiter_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/single_ram_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches last+1, last+2, ... modulo
// NUM_REQ and returns a one-hot grant plus the winning index.
module rr_arbiter
    import single_ram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        found     = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand     = (32'(last) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/single_ram_arbiter.sv
// Round-robin controller sharing one single-port RAM between NUM_REQ
// requesters; one command in flight, IDLE -> ACCESS -> DONE per command.
module single_ram_arbiter
    import single_ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic                          ram_cs,
    output logic                          ram_we,
    output logic                          ram_oe,
    inout  logic [DATA_WIDTH-1:0]         ram_data
);

    localparam int unsigned      IDX_W    = idx_width(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    logic [1:0]            state;
    logic [IDX_W-1:0]      last;
    logic [IDX_W-1:0]      cur_idx;
    logic [IDX_W-1:0]      grant_idx;
    logic [NUM_REQ-1:0]    grant;
    logic                  accept;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  drive_en;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .last      (last),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Accept is gated by rst so req_ready stays at its reset value while rst is held.
    assign accept    = (state == IDLE) && !rst && (|req_valid);
    assign req_ready = accept ? grant : '0;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Strobes are loaded on the accept edge so they are registered during ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= LAST_RST;
            cur_idx   <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            ram_addr  <= '0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            wdata_q   <= '0;
            drive_en  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= ACCESS;
                        last     <= grant_idx;
                        cur_idx  <= grant_idx;
                        ram_cs   <= 1'b1;
                        ram_we   <= sel_we;
                        ram_oe   <= !sel_we;
                        ram_addr <= sel_addr;
                        wdata_q  <= sel_wdata;
                        drive_en <= sel_we;
                    end
                end
                ACCESS: begin
                    state     <= DONE;
                    ram_cs    <= 1'b0;
                    ram_we    <= 1'b0;
                    ram_oe    <= 1'b0;
                    drive_en  <= 1'b0;
                    rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << cur_idx;
                    if (ram_oe) begin
                        rsp_rdata <= ram_data;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    rsp_valid <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ram_data = drive_en ? wdata_q : 'z;

endmodule

// File: tb/tb_single_ram_arbiter.sv
// Directed bench for single_ram_arbiter with a behavioural single-port RAM
// on the shared tristate bus.
module tb_single_ram_arbiter;

    localparam logic [31:0] PROBE = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [7:0]  ram_addr;
    logic        ram_cs;
    logic        ram_we;
    logic        ram_oe;
    wire  [31:0] ram_data;

    logic [31:0] mem [256];
    logic        tb_drv;
    logic [31:0] tb_val;
    logic        probe_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int prev_acc = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [7:0]  addr0;
        logic [7:0]  addr1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        int          g;
        logic        b2b;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    single_ram_arbiter #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .NUM_REQ    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_addr  (ram_addr),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_data  (ram_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: commits writes at the edge, drives the bus while read-enabled.
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
    end

    always_comb begin
        tb_drv = 1'b0;
        tb_val = '0;
        if (ram_cs && ram_oe) begin
            tb_drv = 1'b1;
            tb_val = mem[ram_addr];
        end else if (probe_en) begin
            tb_drv = 1'b1;
            tb_val = PROBE;
        end
    end

    assign ram_data = tb_drv ? tb_val : 'z;

    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (ram_we && ram_oe) begin
                n_fail++;
                $display("FAIL bus_contention: ram_we=%b ram_oe=%b, required not both 1", ram_we, ram_oe);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Controller must not be driving: a lone TB probe must read back intact.
    task automatic probe_bus(input string name);
        probe_en = 1'b1;
        #1;
        check(name, ram_data, PROBE);
        probe_en = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        int unsigned n;
        logic [1:0]  oh;
        logic [7:0]  ea;
        logic [31:0] ew;
        req_valid = v.valid;
        req_we    = v.we;
        req_addr  = {v.addr1, v.addr0};
        req_wdata = {v.wd1, v.wd0};
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        oh = 2'b01 << v.g;
        ea = (v.g == 0) ? v.addr0 : v.addr1;
        ew = (v.g == 0) ? v.wd0 : v.wd1;
        check("req_ready", 32'(req_ready), 32'(oh));
        if (req_ready == 2'b00) begin
            req_valid = '0;
            return;
        end
        if (v.b2b) check("accept_spacing", cyc - prev_acc, 3);
        prev_acc = cyc;
        @(posedge clk); #1;
        check("access_cs", 32'(ram_cs), 1);
        check("access_we", 32'(ram_we), 32'(v.we[v.g]));
        check("access_oe", 32'(ram_oe), 32'(!v.we[v.g]));
        check("access_addr", 32'(ram_addr), 32'(ea));
        check("access_ready", 32'(req_ready), 0);
        check("access_rsp", 32'(rsp_valid), 0);
        if (v.we[v.g]) check("access_wdata", ram_data, ew);
        @(posedge clk); #1;
        check("done_rsp_valid", 32'(rsp_valid), 32'(oh));
        check("done_cs", 32'(ram_cs), 0);
        if (!v.we[v.g]) check("done_rdata", rsp_rdata, v.exp_rdata);
        probe_bus("done_bus_z");
        @(posedge clk); #1;
        check("idle_rsp_valid", 32'(rsp_valid), 0);
        if (!v.we[v.g]) check("rdata_hold", rsp_rdata, v.exp_rdata);
    endtask

    // r0 command accepted, then rst pulsed during its ACCESS cycle.
    task automatic reset_in_access(input logic we, input logic [7:0] addr, input logic [31:0] wd);
        req_valid = 2'b01;
        req_we    = {1'b0, we};
        req_addr  = {8'h00, addr};
        req_wdata = {32'h0, wd};
        #1;
        check("rst_seq_ready", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        check("rst_seq_cs", 32'(ram_cs), 1);
        check("rst_seq_oe", 32'(ram_oe), 32'(!we));
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_seq_rsp_valid", 32'(rsp_valid), 0);
        check("rst_seq_rdata", rsp_rdata, 0);
        check("rst_seq_strobes", {29'h0, ram_cs, ram_we, ram_oe}, 0);
        check("rst_seq_addr", 32'(ram_addr), 0);
        check("rst_seq_ready0", 32'(req_ready), 0);
        probe_bus("rst_seq_bus_z");
        @(posedge clk); #1;
        check("rst_seq_no_rsp", 32'(rsp_valid), 0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        //              valid  we     a0     a1     wd0            wd1            g  b2b   rdata
        vecs[0]  = '{2'b11, 2'b11, 8'h10, 8'h20, 32'h1111_1111, 32'h2222_2222, 0, 1'b0, 32'h0};
        vecs[1]  = '{2'b11, 2'b11, 8'h10, 8'h20, 32'h1111_1111, 32'h2222_2222, 1, 1'b1, 32'h0};
        vecs[2]  = '{2'b01, 2'b00, 8'h10, 8'h00, 32'h0,         32'h0,         0, 1'b1, 32'h1111_1111};
        vecs[3]  = '{2'b10, 2'b00, 8'h00, 8'h20, 32'h0,         32'h0,         1, 1'b1, 32'h2222_2222};
        vecs[4]  = '{2'b01, 2'b01, 8'hA5, 8'h00, 32'hDEAD_BEEF, 32'h0,         0, 1'b1, 32'h0};
        vecs[5]  = '{2'b01, 2'b00, 8'hA5, 8'h00, 32'h0,         32'h0,         0, 1'b1, 32'hDEAD_BEEF};
        vecs[6]  = '{2'b11, 2'b10, 8'h10, 8'h5A, 32'h0,         32'h55AA_FF00, 1, 1'b1, 32'h0};
        vecs[7]  = '{2'b10, 2'b00, 8'h00, 8'h5A, 32'h0,         32'h0,         1, 1'b1, 32'h55AA_FF00};
        for (int i = 8; i < 14; i++) begin
            vecs[i] = '{2'b11, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0, (i % 2), 1'b1,
                        ((i % 2) == 0) ? 32'h1111_1111 : 32'h2222_2222};
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(req_ready), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rdata", rsp_rdata, 0);
        check("reset_strobes", {29'h0, ram_cs, ram_we, ram_oe}, 0);
        check("reset_addr", 32'(ram_addr), 0);
        probe_bus("reset_bus_z");
        req_valid = 2'b11;
        #1;
        check("reset_ready_gated", 32'(req_ready), 0);
        req_valid = '0;
        rst       = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i]);
        end
        req_valid = '0;

        // Write interrupted by reset still lands in the RAM.
        reset_in_access(1'b1, 8'h33, 32'hC0FF_EE11);
        run_txn('{2'b01, 2'b00, 8'h33, 8'h00, 32'h0, 32'h0, 0, 1'b0, 32'hC0FF_EE11});

        // After r0 wins, reset during its read must return the pointer so r0 wins again.
        reset_in_access(1'b0, 8'h10, 32'h0);
        run_txn('{2'b11, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0, 0, 1'b0, 32'h1111_1111});

        // r1 raises and withdraws its command while r0 is in flight.
        req_valid = 2'b01;
        req_we    = 2'b11;
        req_addr  = {8'h77, 8'h61};
        req_wdata = {32'h7777_7777, 32'h6161_6161};
        #1;
        check("withdraw_ready_r0", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        req_valid = 2'b10;
        #1;
        check("withdraw_ready_access", 32'(req_ready), 0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("withdraw_ready_idle", 32'(req_ready), 0);
            check("withdraw_cs_idle", 32'(ram_cs), 0);
        end
        run_txn('{2'b01, 2'b00, 8'h61, 8'h00, 32'h0, 32'h0, 0, 1'b0, 32'h6161_6161});
        req_valid = '0;

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
